// File: rtl/tlm_result_collector.sv
// Two-bank ping-pong capture buffer for the BFM result stream, with per-batch
// checksum, valid/ack batch presentation, registered read port and drop accounting.
module tlm_result_collector #(
    parameter int NUM        = 1000,
    parameter int ITEM_WIDTH = 8,
    parameter int SUM_WIDTH  = ITEM_WIDTH + $clog2(NUM),
    parameter int AW         = $clog2(NUM)
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  valid_i,
    input  logic [ITEM_WIDTH-1:0] res_i,
    output logic                  batch_valid_o,
    output logic                  batch_bank_o,
    output logic [SUM_WIDTH-1:0]  batch_sum_o,
    input  logic                  batch_ack_i,
    input  logic [AW-1:0]         rd_addr_i,
    output logic [ITEM_WIDTH-1:0] rd_data_o,
    output logic [31:0]           drop_cnt_o,
    output logic                  overflow_o
);

    localparam logic [1:0] ST_FREE    = 2'd0;
    localparam logic [1:0] ST_FILLING = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    logic [1:0]            r_state [2];
    logic [SUM_WIDTH-1:0]  r_sum [2];
    logic [ITEM_WIDTH-1:0] r_mem [2][NUM];
    logic [AW-1:0]         r_wp;
    logic                  r_wb;
    logic                  r_order;
    logic [31:0]           r_dropCnt;
    logic                  r_overflow;
    logic [ITEM_WIDTH-1:0] r_rdData;

    logic       w_wr;
    logic       w_last;
    logic       w_drop;
    logic       w_full0;
    logic       w_full1;
    logic       w_valid;
    logic       w_pres;
    logic       w_ack;
    logic       w_nextWb;
    logic       w_nextOrder;
    logic [1:0] w_nextState [2];

    // Only bank wb can ever be FILLING, so its state alone decides write vs. drop.
    always_comb begin
        w_wr     = valid_i && (r_state[r_wb] == ST_FILLING);
        w_last   = w_wr && (r_wp == AW'(NUM - 1));
        w_drop   = valid_i && !w_wr;
        w_full0  = (r_state[0] == ST_FULL);
        w_full1  = (r_state[1] == ST_FULL);
        w_valid  = w_full0 || w_full1;
        w_pres   = (w_full0 && w_full1) ? r_order : w_full1;
        w_ack    = batch_ack_i && w_valid;
        w_nextWb = w_last ? ~r_wb : r_wb;

        for (int b = 0; b < 2; b++) begin
            w_nextState[b] = r_state[b];
            if (w_ack && (w_pres == 1'(b)))
                w_nextState[b] = ST_FREE;
            if (w_last && (r_wb == 1'(b)))
                w_nextState[b] = ST_FULL;
        end
        // A pending write bank starts filling as soon as it is free, including when freed by this ack.
        if (w_nextState[w_nextWb] == ST_FREE)
            w_nextState[w_nextWb] = ST_FILLING;

        w_nextOrder = r_order;
        if (w_ack)
            w_nextOrder = ~w_pres;
        if (w_last && (w_nextState[~r_wb] != ST_FULL))
            w_nextOrder = r_wb;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state[0] <= ST_FILLING;
            r_state[1] <= ST_FREE;
            r_sum[0]   <= '0;
            r_sum[1]   <= '0;
            r_wp       <= '0;
            r_wb       <= 1'b0;
            r_order    <= 1'b0;
            r_dropCnt  <= '0;
            r_overflow <= 1'b0;
            r_rdData   <= '0;
        end else begin
            r_state[0] <= w_nextState[0];
            r_state[1] <= w_nextState[1];
            if (w_wr)
                r_sum[r_wb] <= r_sum[r_wb] + SUM_WIDTH'(res_i);
            if (w_ack)
                r_sum[w_pres] <= '0;
            if (w_wr)
                r_wp <= w_last ? '0 : r_wp + AW'(1);
            r_wb    <= w_nextWb;
            r_order <= w_nextOrder;
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_dropCnt != '1)
                    r_dropCnt <= r_dropCnt + 32'd1;
            end
            if (32'(rd_addr_i) < NUM)
                r_rdData <= r_mem[w_pres][rd_addr_i];
            else
                r_rdData <= '0;
        end
    end

    // Storage is deliberately left uncleared by reset; bank state gates what is presented.
    always_ff @(posedge clk_i) begin
        if (w_wr)
            r_mem[r_wb][r_wp] <= res_i;
    end

    assign batch_valid_o = w_valid;
    assign batch_bank_o  = w_pres;
    assign batch_sum_o   = w_valid ? r_sum[w_pres] : '0;
    assign rd_data_o     = r_rdData;
    assign drop_cnt_o    = r_dropCnt;
    assign overflow_o    = r_overflow;

endmodule

// File: tb/tb_tlm_result_collector.sv
// Directed, table-driven bench for tlm_result_collector with NUM=4, ITEM_WIDTH=8.
module tb_tlm_result_collector;

    localparam int NUM = 4;
    localparam int IW  = 8;
    localparam int SW  = 10;
    localparam int AW  = 2;

    logic          clk_i = 1'b0;
    logic          reset_ni;
    logic          valid_i;
    logic [IW-1:0] res_i;
    logic          batch_valid_o;
    logic          batch_bank_o;
    logic [SW-1:0] batch_sum_o;
    logic          batch_ack_i;
    logic [AW-1:0] rd_addr_i;
    logic [IW-1:0] rd_data_o;
    logic [31:0]   drop_cnt_o;
    logic          overflow_o;

    int testsRun = 0;
    int testsFailed = 0;

    tlm_result_collector #(
        .NUM(NUM), .ITEM_WIDTH(IW), .SUM_WIDTH(SW), .AW(AW)
    ) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .valid_i(valid_i), .res_i(res_i),
        .batch_valid_o(batch_valid_o), .batch_bank_o(batch_bank_o),
        .batch_sum_o(batch_sum_o), .batch_ack_i(batch_ack_i),
        .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
        .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          rst;
        bit          v;
        logic [7:0]  res;
        bit          ack;
        logic [1:0]  addr;
        bit          chkRd;
        logic        expValid;
        logic        expBank;
        logic [9:0]  expSum;
        logic [31:0] expDrop;
        logic        expOvf;
        logic [7:0]  expRd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit v, logic [7:0] res, bit ack, logic [1:0] addr,
                                bit chkRd, logic ev, logic eb, logic [9:0] es,
                                logic [31:0] ed, logic eo, logic [7:0] er);
        vec_t t;
        t.rst = rst; t.v = v; t.res = res; t.ack = ack; t.addr = addr; t.chkRd = chkRd;
        t.expValid = ev; t.expBank = eb; t.expSum = es; t.expDrop = ed; t.expOvf = eo; t.expRd = er;
        return t;
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(bit v, logic [7:0] res, bit ack, logic [1:0] addr);
        valid_i     = v;
        res_i       = res;
        batch_ack_i = ack;
        rd_addr_i   = addr;
        @(posedge clk_i);
        #1;
        valid_i     = 1'b0;
        batch_ack_i = 1'b0;
    endtask

    // Asynchronous reset pulse placed between edges (called 1ns after an edge).
    task automatic pulseReset(bit doCheck);
        reset_ni = 1'b0;
        #2;
        if (doCheck) begin
            checkOutput("rst_valid", 32'(batch_valid_o), 32'd0);
            checkOutput("rst_bank", 32'(batch_bank_o), 32'd0);
            checkOutput("rst_sum", 32'(batch_sum_o), 32'd0);
            checkOutput("rst_rd", 32'(rd_data_o), 32'd0);
            checkOutput("rst_drop", drop_cnt_o, 32'd0);
            checkOutput("rst_ovf", 32'(overflow_o), 32'd0);
        end
        reset_ni = 1'b1;
        #1;
    endtask

    task automatic checkBatch(string tag, logic ev, logic eb, logic [9:0] es);
        checkOutput({tag, "_valid"}, 32'(batch_valid_o), 32'(ev));
        checkOutput({tag, "_bank"}, 32'(batch_bank_o), 32'(eb));
        checkOutput({tag, "_sum"}, 32'(batch_sum_o), 32'(es));
    endtask

    initial begin
        // Single batch 1..4, read back, ack.
        vecs.push_back(mk(1, 1, 8'd1, 0, 0, 0, 0, 0, 10'd0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'd2, 0, 0, 0, 0, 0, 10'd0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'd3, 0, 0, 0, 0, 0, 10'd0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'd4, 0, 0, 0, 1, 0, 10'd10, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0, 0, 0, 1, 1, 0, 10'd10, 0, 0, 8'd1));
        vecs.push_back(mk(0, 0, 8'd0, 0, 1, 1, 1, 0, 10'd10, 0, 0, 8'd2));
        vecs.push_back(mk(0, 0, 8'd0, 0, 2, 1, 1, 0, 10'd10, 0, 0, 8'd3));
        vecs.push_back(mk(0, 0, 8'd0, 0, 3, 1, 1, 0, 10'd10, 0, 0, 8'd4));
        vecs.push_back(mk(0, 0, 8'd0, 1, 0, 0, 0, 0, 10'd0, 0, 0, 0));
        // Ping-pong 10..17, overflow by 3, then 4 x 0xFF into the recycled bank 0.
        vecs.push_back(mk(1, 1, 8'd10, 0, 0, 0, 0, 0, 10'd0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'd11, 0, 0, 0, 0, 0, 10'd0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'd12, 0, 0, 0, 0, 0, 10'd0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'd13, 0, 0, 0, 1, 0, 10'd46, 0, 0, 0));
        for (int i = 14; i <= 17; i++)
            vecs.push_back(mk(0, 1, 8'(i), 0, 0, 0, 1, 0, 10'd46, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'd1, 0, 0, 0, 1, 0, 10'd46, 1, 1, 0));
        vecs.push_back(mk(0, 1, 8'd2, 0, 0, 0, 1, 0, 10'd46, 2, 1, 0));
        vecs.push_back(mk(0, 1, 8'd3, 0, 0, 0, 1, 0, 10'd46, 3, 1, 0));
        vecs.push_back(mk(0, 0, 8'd0, 1, 0, 0, 1, 1, 10'd62, 3, 1, 0));
        vecs.push_back(mk(0, 0, 8'd0, 0, 3, 1, 1, 1, 10'd62, 3, 1, 8'd17));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 1, 8'hFF, 0, 0, 0, 1, 1, 10'd62, 3, 1, 0));
        vecs.push_back(mk(0, 0, 8'd0, 1, 0, 0, 1, 0, 10'h3FC, 3, 1, 0));
        vecs.push_back(mk(0, 0, 8'd0, 0, 0, 1, 1, 0, 10'h3FC, 3, 1, 8'hFF));
        vecs.push_back(mk(0, 0, 8'd0, 1, 0, 0, 0, 0, 10'd0, 3, 1, 0));
        // Completion of bank 1 on the same edge as the ack of bank 0.
        vecs.push_back(mk(1, 1, 8'd1, 0, 0, 0, 0, 0, 10'd0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'd2, 0, 0, 0, 0, 0, 10'd0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'd3, 0, 0, 0, 0, 0, 10'd0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'd4, 0, 0, 0, 1, 0, 10'd10, 0, 0, 0));
        for (int i = 5; i <= 7; i++)
            vecs.push_back(mk(0, 1, 8'(i), 0, 0, 0, 1, 0, 10'd10, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'd8, 1, 0, 0, 1, 1, 10'd26, 0, 0, 0));
        for (int i = 9; i <= 12; i++)
            vecs.push_back(mk(0, 1, 8'(i), 0, 0, 0, 1, 1, 10'd26, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0, 1, 0, 0, 1, 0, 10'd42, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0, 0, 0, 1, 1, 0, 10'd42, 0, 0, 8'd9));
        vecs.push_back(mk(0, 0, 8'd0, 1, 0, 0, 0, 0, 10'd0, 0, 0, 0));

        reset_ni = 1'b0; valid_i = 1'b0; res_i = '0; batch_ack_i = 1'b0; rd_addr_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        checkBatch("por", 1'b0, 1'b0, 10'd0);
        checkOutput("por_rd", 32'(rd_data_o), 32'd0);
        checkOutput("por_drop", drop_cnt_o, 32'd0);
        checkOutput("por_ovf", 32'(overflow_o), 32'd0);
        reset_ni = 1'b1;
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst)
                pulseReset(1'b0);
            applyStimulus(vecs[i].v, vecs[i].res, vecs[i].ack, vecs[i].addr);
            checkBatch($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expBank, vecs[i].expSum);
            checkOutput($sformatf("vec%0d_drop", i), drop_cnt_o, vecs[i].expDrop);
            checkOutput($sformatf("vec%0d_ovf", i), 32'(overflow_o), 32'(vecs[i].expOvf));
            if (vecs[i].chkRd)
                checkOutput($sformatf("vec%0d_rd", i), 32'(rd_data_o), 32'(vecs[i].expRd));
        end

        // Async reset from a busy, overflowed state clears every output at once.
        pulseReset(1'b0);
        for (int i = 1; i <= 9; i++)
            applyStimulus(1'b1, 8'(i), 1'b0, 2'd0);
        applyStimulus(1'b0, 8'd0, 1'b0, 2'd0);
        checkBatch("busy", 1'b1, 1'b0, 10'd10);
        checkOutput("busy_drop", drop_cnt_o, 32'd1);
        checkOutput("busy_rd", 32'(rd_data_o), 32'd1);
        pulseReset(1'b1);

        // Reset mid-fill discards the partial batch.
        applyStimulus(1'b1, 8'd7, 1'b0, 2'd0);
        applyStimulus(1'b1, 8'd8, 1'b0, 2'd0);
        pulseReset(1'b1);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 8'd5, 1'b0, 2'd0);
        checkBatch("midrst3", 1'b0, 1'b0, 10'd0);
        applyStimulus(1'b1, 8'd5, 1'b0, 2'd0);
        checkBatch("midrst4", 1'b1, 1'b0, 10'd20);
        applyStimulus(1'b0, 8'd0, 1'b1, 2'd0);
        checkBatch("midrstAck", 1'b0, 1'b0, 10'd0);

        // Spurious ack during a fill must not disturb bank 0.
        pulseReset(1'b0);
        applyStimulus(1'b1, 8'd1, 1'b0, 2'd0);
        applyStimulus(1'b1, 8'd2, 1'b0, 2'd0);
        applyStimulus(1'b0, 8'd0, 1'b1, 2'd0);
        checkBatch("spur", 1'b0, 1'b0, 10'd0);
        applyStimulus(1'b1, 8'd3, 1'b0, 2'd0);
        applyStimulus(1'b1, 8'd4, 1'b0, 2'd0);
        checkBatch("spurDone", 1'b1, 1'b0, 10'd10);
        checkOutput("spur_drop", drop_cnt_o, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/tlm_result_collector.md
# tlm_result_collector

Downstream capture stage for the TLM stimulus path. It samples the per-cycle result stream produced by the BFM (`res_o`, qualified by a valid strobe) into a two-bank ping-pong buffer of `NUM` items per bank. It computes a per-batch checksum and presents each completed batch to the software/DPI side through a valid/ack handshake and a registered read port. The BFM has no backpressure, so items that arrive while both banks are occupied are dropped and counted.

## Interface
- `NUM`, 1000, items per batch (per bank); must be ≥ 2
- `ITEM_WIDTH`, 8, bits per result item
- `SUM_WIDTH`, `ITEM_WIDTH + $clog2(NUM)`, checksum width
- `AW`, `$clog2(NUM)`, read address width

Ports:
- `clk_i`  in  1  single clock, all logic on the rising edge
- `reset_ni`  in  1  asynchronous, active-low reset
- `valid_i`  in  1  `res_i` holds a valid result this cycle
- `res_i`  in  ITEM_WIDTH  result item from the BFM
- `batch_valid_o`  out  1  a completed batch is presented
- `batch_bank_o`  out  1  bank index of the presented batch
- `batch_sum_o`  out  SUM_WIDTH  checksum of the presented batch
- `batch_ack_i`  in  1  consumer releases the presented batch
- `rd_addr_i`  in  AW  item index within the presented batch
- `rd_data_o`  out  ITEM_WIDTH  registered read data
- `drop_cnt_o`  out  32  saturating count of dropped items
- `overflow_o`  out  1  sticky; set on the first drop

## Operation
- State per bank: FREE, FILLING, or FULL. After reset, bank 0 is FILLING, bank 1 is FREE, write pointer `wp` = 0, and write bank `wb` = 0.
- Write path:
  - On `valid_i` with bank `wb` FILLING: `mem[wb][wp] <= res_i`, `sum[wb] <= sum[wb] + res_i` (mod 2^SUM_WIDTH), and `wp` increments.
  - When `wp == NUM-1` is written, bank `wb` becomes FULL, `wp` returns to 0, and `wb` toggles.
  - The new `wb` becomes FILLING only if it is FREE. Otherwise it stays pending and accepts no writes.
- Drop: `valid_i` while no bank is FILLING drops the item. `drop_cnt_o` increments, saturating at 2^32-1, and `overflow_o` is set. A dropped item does not advance `wp` and does not affect any sum.
- Presentation:
  - `batch_valid_o` = 1 whenever some bank is FULL. It presents the oldest FULL bank; an order bit records which bank completed first.
  - `batch_bank_o` and `batch_sum_o` reflect that bank.
- Ack:
  - `batch_ack_i` with `batch_valid_o` = 1 frees the presented bank and clears its sum to 0.
  - If that bank is the pending `wb`, it becomes FILLING in the same edge.
  - `batch_ack_i` with `batch_valid_o` = 0 is ignored.
- Simultaneous events:
  - Completion of bank X and ack of bank Y≠X on the same edge: Y is freed and becomes the FILLING bank, and X is presented next cycle. No drop occurs on the following cycle.
  - A write and an ack never target the same bank.
- Read: `rd_data_o <= mem[batch_bank_o][rd_addr_i]`. An `rd_addr_i` ≥ NUM returns 0.
- Reset:
  - Asserting `reset_ni` mid-operation discards both banks: states, sums, `wp`, `wb`, the order bit, `drop_cnt_o` and `overflow_o` all return to their reset values.
  - Memory contents are not cleared and are never presented unless rewritten.

## Timing
- Reset values:
  - `batch_valid_o` = 0, `batch_bank_o` = 0, `batch_sum_o` = 0
  - `rd_data_o` = 0, `drop_cnt_o` = 0, `overflow_o` = 0
- Item write takes effect on the edge where `valid_i` is sampled. Back-to-back `valid_i` is supported at 1 item/cycle.
- Completion latency: `batch_valid_o` rises the cycle after the edge that samples item NUM-1. `batch_sum_o` is final at that same time and includes the last item.
- Handshake:
  - `batch_valid_o`, `batch_bank_o` and `batch_sum_o` are stable until acked.
  - After the ack edge, `batch_valid_o` drops next cycle unless a second FULL bank exists; in that case it stays high and `batch_bank_o` switches.
- Read latency: 1 cycle from `rd_addr_i` to `rd_data_o`.
- Drop accounting: `drop_cnt_o` and `overflow_o` update on the edge that samples the dropped `valid_i`.

## Test plan
Each scenario uses NUM=4 and ITEM_WIDTH=8.
- Single batch: send items 1, 2, 3, 4 back-to-back.
  - → `batch_valid_o` = 1 one cycle after item 4, with `batch_bank_o` = 0 and `batch_sum_o` = 10.
  - Reading addresses 0..3 returns 1, 2, 3, 4, each one cycle after its address.
  - Ack → `batch_valid_o` = 0.
- Ping-pong without ack: send 8 items, 10..17.
  - → Bank 0 presented with sum 46.
  - After ack, bank 1 is presented with sum 62.
  - `drop_cnt_o` = 0.
- Overflow: with both banks FULL and no ack, send 3 more items.
  - → `drop_cnt_o` = 3 and `overflow_o` = 1.
  - Ack bank 0, then send 4 items of 0xFF → sum 0x3FC, which fits SUM_WIDTH = 10.
- Simultaneous completion and ack: ack bank 0 on the same edge that bank 1's last item is sampled, with items continuing.
  - → Bank 1 is presented next cycle.
  - The next item is written to bank 0 address 0, with no drop.
- Reset mid-fill: send 2 items, pulse `reset_ni` low asynchronously between edges.
  - → All outputs return to 0 immediately.
  - Then send 4 items 5, 5, 5, 5 → sum 20, bank 0.
- Spurious ack: pulse `batch_ack_i` with `batch_valid_o` = 0 → no state change. The next batch still completes on bank 0.
